// File: rtl/shift_pkg.sv
// Shared types for the shift datapath: deserializer FSM states and shift direction.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shifter: moves the word one place and inserts the fill bit at the vacated end.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] word,
   input  logic             fill,
   input  dir_t             dir,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      if (dir == DIR_RIGHT) begin
         shifted = {fill, word[WIDTH-1:1]};
      end else begin
         shifted = {word[WIDTH-2:0], fill};
      end
   end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: rebuilds WIDTH-bit words from a one-bit stream
// with valid/ready on both sides and one extra word of buffering in sr.
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_dir,
   input  logic             clr,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] sr, sr_n, shifted, m_data_n;
   logic [CW-1:0]    cnt, cnt_n;
   dir_t             dir_q, dir_q_n, step_dir;
   logic             m_valid_n, accept, out_free;

   assign s_ready  = (state != FULL) && !clr;
   assign accept   = s_valid && s_ready;
   assign out_free = !m_valid || m_ready;
   // The first bit of a word shifts with the live direction input; later bits use the latched one.
   assign step_dir = (state == IDLE) ? dir_t'(s_dir) : dir_q;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .word    (sr),
      .fill    (s_data),
      .dir     (step_dir),
      .shifted (shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         dir_q   <= DIR_LEFT;
         m_data  <= '0;
         m_valid <= 1'b0;
      end else begin
         state   <= state_n;
         sr      <= sr_n;
         cnt     <= cnt_n;
         dir_q   <= dir_q_n;
         m_data  <= m_data_n;
         m_valid <= m_valid_n;
      end
   end

   always_comb begin
      state_n   = state;
      sr_n      = sr;
      cnt_n     = cnt;
      dir_q_n   = dir_q;
      m_data_n  = m_data;
      m_valid_n = m_valid && !m_ready;
      unique case (state)
         IDLE: begin
            if (clr) begin
               sr_n  = '0;
               cnt_n = '0;
            end else if (accept) begin
               dir_q_n = dir_t'(s_dir);
               sr_n    = shifted;
               cnt_n   = CW'(1);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (clr) begin
               sr_n    = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (accept) begin
               if (cnt == LAST) begin
                  if (out_free) begin
                     m_data_n  = shifted;
                     m_valid_n = 1'b1;
                     cnt_n     = '0;
                     state_n   = IDLE;
                  end else begin
                     sr_n    = shifted;
                     state_n = FULL;
                  end
               end else begin
                  sr_n  = shifted;
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         FULL: begin
            // A flush drops the pending word; it does not block the consumer from draining m_data.
            if (clr) begin
               sr_n    = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (m_ready) begin
               m_data_n  = sr;
               m_valid_n = 1'b1;
               cnt_n     = '0;
               state_n   = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: directed scenarios plus randomized traffic
// checked against a word-level model of accepted bits and a two-slot output buffer.
module tb_shift_deserializer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_data, s_valid, s_dir, clr, m_ready;
   logic             s_ready, m_valid;
   logic [WIDTH-1:0] m_data;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] exp_q[$];
   logic             part_bits[$];
   logic             part_dir;
   logic [WIDTH-1:0] exp_word;

   shift_deserializer #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_dir   (s_dir),
      .clr     (clr),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word from the model's collected bits: first bit lands in the MSB (left) or LSB (right).
   function automatic logic [WIDTH-1:0] assemble();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (part_dir == 1'b0) w[WIDTH-1-i] = part_bits[i];
         else                  w[i]         = part_bits[i];
      end
      return w;
   endfunction

   always @(posedge rst) begin
      exp_q.delete();
      part_bits.delete();
   end

   // Monitor and reference model: exp_q holds words completed but not yet consumed,
   // so one entry means m_data is occupied and two mean a word is pending behind it.
   always @(negedge clk) begin
      int n;
      if (rst) begin
         check("reset m_valid", m_valid, 0);
         check("reset m_data", m_data, 0);
         exp_q.delete();
         part_bits.delete();
      end else begin
         n = exp_q.size();
         check("s_ready", s_ready, (n < 2) && !clr);
         check("m_valid", m_valid, n >= 1);
         if (clr) begin
            part_bits.delete();
            if (n == 2) void'(exp_q.pop_back());
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious word", 0, 1);
            end else begin
               exp_word = exp_q.pop_front();
               check("m_data", m_data, exp_word);
            end
         end
         if (s_valid && (n < 2) && !clr) begin
            if (part_bits.size() == 0) part_dir = s_dir;
            part_bits.push_back(s_data);
            if (part_bits.size() == WIDTH) begin
               exp_q.push_back(assemble());
               part_bits.delete();
            end
         end
      end
   end

   task automatic applyStimulus(input logic d, input logic dir, input logic v,
                                input logic mr, input logic c);
      @(posedge clk);
      #1;
      s_data  = d;
      s_dir   = dir;
      s_valid = v;
      m_ready = mr;
      clr     = c;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] d, input logic v);
      check({name, " data"}, m_data, d);
      check({name, " valid"}, m_valid, v);
   endtask

   task automatic sendWord(input logic [WIDTH-1:0] w, input logic dir, input logic mr);
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(dir ? w[i] : w[WIDTH-1-i], dir, 1'b1, mr, 1'b0);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] words[3];
      logic [WIDTH-1:0] bits_l;
      rst = 1'b1; s_data = 0; s_dir = 0; s_valid = 0; clr = 0; m_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("ready after reset", s_ready, 1);

      // Basic left and right assembly
      sendWord(4'b1011, 1'b0, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("basic left", 4'b1011, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("basic left pulse", 4'b1011, 1'b0);
      bits_l = 4'b1101;
      sendWord(bits_l, 1'b1, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("basic right", 4'b1101, 1'b1);

      // Direction is sampled on the first bit only
      applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(1, 1, 1, 1, 0);
      applyStimulus(0, 1, 1, 1, 0);
      applyStimulus(0, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("dir sampling", 4'b1100, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);

      // Back-pressure: two words buffered, s_ready low while full
      sendWord(4'hB, 1'b0, 1'b0);
      sendWord(4'h6, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("bp held", 4'hB, 1'b1);
      check("bp s_ready low", s_ready, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("bp second", 4'h6, 1'b1);
      check("bp s_ready back", s_ready, 1);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      check("bp drained", m_valid, 0);

      // Streaming without bubbles
      words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
      for (int j = 0; j <= 3 * WIDTH; j++) begin
         if (j < 3 * WIDTH) begin
            bits_l = words[j / WIDTH];
            applyStimulus(bits_l[WIDTH-1-(j % WIDTH)], 0, 1, 1, 0);
         end else begin
            applyStimulus(0, 0, 0, 1, 0);
         end
         if (j > 0 && (j % WIDTH) == 0) checkOutput("stream word", words[j / WIDTH - 1], 1'b1);
         else if (j > 0) check("stream gap", m_valid, 0);
      end

      // Flush a partial word, then assemble cleanly
      applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 1, 1);
      sendWord(4'h6, 1'b0, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("after flush", 4'h6, 1'b1);

      // Asynchronous reset mid-word
      applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 1, 0);
      @(posedge clk);
      #1 s_valid = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      checkOutput("mid-word reset", 4'h0, 1'b0);
      check("reset s_ready", s_ready, 1);
      sendWord(4'hA, 1'b0, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("after reset", 4'hA, 1'b1);

      // Randomized traffic with occasional flushes and resets
      for (int k = 0; k < 600; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
                       $urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      repeat (6) applyStimulus(0, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

- Serial-in, parallel-out receiver that rebuilds WIDTH-bit words from a one-bit stream.
- Serves as the receiving end of the lab's shift datapath: bits arrive MSB-first (left shifts) or LSB-first (right shifts), matching the left/right one-bit shifter convention.
- A valid/ready handshake sits on both sides. A one-word output register plus a holding state absorb back-pressure without losing bits.

## Interface
- WIDTH, 4, word width; legal range WIDTH >= 2.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_data  input  1  serial bit.
- s_valid  input  1  s_data valid.
- s_ready  output  1  bit accepted when s_valid & s_ready.
- s_dir  input  1  0 = left (MSB-first), 1 = right (LSB-first). Sampled only on the first bit of a word.
- clr  input  1  synchronous flush of the partial word.
- m_data  output  WIDTH  assembled word (registered).
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer takes word when m_valid & m_ready.

## Operation
- State machine states:
  - IDLE: no partial word.
  - SHIFT: 1..WIDTH-1 bits held.
  - FULL: complete word waiting for the output register.
- Registers:
  - sr[WIDTH-1:0].
  - cnt, ceil(log2 WIDTH) bits.
  - dir_q.
  - state.
  - m_data, m_valid.
- Shift step on each accepted bit:
  - Left: sr <= {sr[WIDTH-2:0], s_data}.
  - Right: sr <= {s_data, sr[WIDTH-1:1]}.
  - Net effect: the first bit lands in the MSB (left) or the LSB (right).
- s_ready = (state != FULL) & ~clr.
- IDLE, bit accepted: dir_q <= s_dir; the shift uses s_dir directly; cnt <= 1; go to SHIFT.
- SHIFT, bit accepted with cnt < WIDTH-1: shift using dir_q; cnt++.
- SHIFT, bit accepted with cnt == WIDTH-1 (word complete):
  - If the output is free (~m_valid | m_ready): m_data <= shifted word; m_valid <= 1; cnt <= 0; go to IDLE.
  - Otherwise: sr <= shifted word; go to FULL.
- FULL, m_ready (m_valid is necessarily 1): m_data <= sr; m_valid stays 1; cnt <= 0; go to IDLE.
- Output register with no word arriving: m_valid & m_ready clears m_valid.
- clr:
  - In IDLE or SHIFT: sr <= 0, cnt <= 0, go to IDLE.
  - In FULL: discards the pending word, goes to IDLE.
  - Never touches m_data or m_valid.
  - Has priority over any bit: s_ready is forced low, so no bit is consumed.
- dir_q is ignored in IDLE. s_dir is ignored outside the first bit.

## Timing
- Reset values: sr=0, cnt=0, dir_q=0, state=IDLE, m_data=0, m_valid=0. s_ready=1 once rst is released (if clr=0).
- Latency: last bit accepted in cycle n gives m_valid=1 in cycle n+1, provided the output was free in cycle n.
- Throughput: one word per WIDTH cycles with s_valid and m_ready held high; no bubbles.
- Back-pressure:
  - At most two words are buffered (m_data and sr).
  - s_ready is low for the whole FULL state.
  - The FULL to IDLE transfer costs one cycle. The first bit of the next word is accepted in the cycle after the m_ready handshake.
- Simultaneous events:
  - Consume of the old word and completion of a new word in the same cycle: the new word replaces the old, m_valid stays 1.
  - clr together with a last bit: the bit is not accepted and the word is lost.
- Reset mid-word or in FULL: every partial or pending word is dropped, and the next accepted bit starts a fresh word.

## Structure
- Package shift_pkg:
  - Enum state_t {IDLE, SHIFT, FULL}.
  - Enum dir_t {DIR_LEFT=0, DIR_RIGHT=1}.
- Sub-module shift_step:
  - Combinational, parameterised WIDTH.
  - Inputs: word, fill bit, dir. Output: the shifted word.
  - Instantiated once; the deserializer drives its dir from s_dir in IDLE and from dir_q otherwise.

## Test plan
- Basic left: dir=0, bits 1,0,1,1, m_ready=1 -> m_data=4'b1011, m_valid for 1 cycle, one cycle after the 4th bit.
- Basic right: dir=1, bits 1,0,1,1 -> m_data=4'b1101.
- Back-pressure: m_ready=0, stream words 4'hB then 4'h6 (MSB-first):
  - s_ready drops after the 8th bit; m_data=4'hB.
  - Pulse m_ready -> next cycle m_data=4'h6, s_ready=1.
- Streaming: 3 back-to-back words 4'hA, 4'h5, 4'hF with m_ready=1 -> m_valid rises at cycles 5, 9, 13 with those values.
- Direction sampling: s_dir=0 on bit 1, toggled on bits 2-4, bits 1,1,0,0 -> m_data=4'b1100.
- Flush and reset:
  - 2 bits, then clr -> no m_valid; the next 4 bits 0,1,1,0 give 4'h6.
  - 3 bits, then async rst pulse -> all outputs at reset values; the next word assembles cleanly.
